// File: rtl/output_switch_ctrl.sv
// output_switch_ctrl: debounced, gap-aware channel switch sequencer for the
// 4-channel TS output selector. Changes SELECT only between packets (or after
// a timeout), issues a fixed-length downstream reset, then hunts for the
// first packet sync on the new channel before reporting LOCKED.
module output_switch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 65535,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] SW,
    input  logic [3:0] D_VALID_BUS,
    input  logic [3:0] P_SYNC_BUS,
    output logic [1:0] SELECT,
    output logic       RESET_ON_CHANGE_OUT,
    output logic       LOCKED,
    output logic       TIMEOUT_ERR
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GAP,
        RST_PULSE,
        WAIT_SYNC
    } state_t;

    logic [1:0]       sw_m;
    logic [1:0]       sw_s;
    logic [1:0]       cand;
    logic [CNT_W-1:0] deb_cnt;
    logic [1:0]       req;

    state_t           state;
    state_t           state_n;
    logic [1:0]       target;
    logic [1:0]       target_n;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic [1:0]       select_n;
    logic             roc_n;
    logic             locked_n;
    logic             terr_n;

    logic             cur_valid;
    logic             cur_sync;

    assign cur_valid = D_VALID_BUS[SELECT];
    assign cur_sync  = P_SYNC_BUS[SELECT];

    // Two-flop synchronizer for the asynchronous front-panel switch
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= SW;
            sw_s <= sw_m;
        end
    end

    // Debounce: accept a switch value after it has been stable long enough
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cand    <= '0;
            deb_cnt <= '0;
            req     <= '0;
        end else if (sw_s != cand) begin
            cand    <= sw_s;
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            req <= cand;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state               <= WAIT_SYNC;
            target              <= '0;
            timer               <= '0;
            SELECT              <= '0;
            RESET_ON_CHANGE_OUT <= 1'b0;
            LOCKED              <= 1'b0;
            TIMEOUT_ERR         <= 1'b0;
        end else begin
            state               <= state_n;
            target              <= target_n;
            timer               <= timer_n;
            SELECT              <= select_n;
            RESET_ON_CHANGE_OUT <= roc_n;
            LOCKED              <= locked_n;
            TIMEOUT_ERR         <= terr_n;
        end
    end

    // Next-state and next-output logic; the timer restarts on every state entry
    always_comb begin
        state_n  = state;
        target_n = target;
        timer_n  = timer + CNT_W'(1);
        select_n = SELECT;
        roc_n    = RESET_ON_CHANGE_OUT;
        locked_n = LOCKED;
        terr_n   = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (req != SELECT) begin
                    target_n = req;
                    locked_n = 1'b0;
                    state_n  = WAIT_GAP;
                end
            end

            WAIT_GAP: begin
                if (!cur_valid || timer == TO_LAST) begin
                    // Exit with data still valid means the gap never came
                    terr_n   = cur_valid;
                    select_n = target;
                    roc_n    = 1'b1;
                    state_n  = RST_PULSE;
                    timer_n  = '0;
                end
            end

            RST_PULSE: begin
                if (timer == RST_LAST) begin
                    roc_n   = 1'b0;
                    state_n = WAIT_SYNC;
                    timer_n = '0;
                end
            end

            WAIT_SYNC: begin
                if (req != SELECT) begin
                    // Output is already unlocked, so re-target without a gap wait
                    target_n = req;
                    select_n = req;
                    roc_n    = 1'b1;
                    state_n  = RST_PULSE;
                    timer_n  = '0;
                end else if (cur_sync && cur_valid) begin
                    locked_n = 1'b1;
                    state_n  = IDLE;
                    timer_n  = '0;
                end else if (timer == TO_LAST) begin
                    terr_n  = 1'b1;
                    timer_n = '0;
                end
            end

            default: begin
                state_n = WAIT_SYNC;
                timer_n = '0;
            end
        endcase
    end

endmodule

// File: doc/output_switch_ctrl.md
# output_switch_ctrl

Sequencing controller for the 4-channel TS output selector feeding the ASI transmitter. It debounces the front-panel channel switch and waits for an inter-packet gap on the current channel. It then changes the channel select with a fixed-length downstream reset pulse and hunts for the first packet sync on the new channel before reporting lock. All TS status inputs are already synchronous to CLK; only SW is asynchronous.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles of synchronized SW required to accept a new request (≥1).
- RESET_CYCLES, 16: length of RESET_ON_CHANGE_OUT pulse in CLK cycles (≥1).
- TIMEOUT_CYCLES, 65535: gap-wait / sync-hunt timeout in CLK cycles (≥2).
- CNT_W, 16: width of the debounce, reset and timeout counters; all cycle parameters must be < 2^CNT_W.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- SW  in  2  raw channel switch, asynchronous.
- D_VALID_BUS  in  4  per-channel data-valid, bit i = channel i.
- P_SYNC_BUS  in  4  per-channel packet-sync (first byte of packet).
- SELECT  out  2  registered channel select driving the output mux.
- RESET_ON_CHANGE_OUT  out  1  registered reset to downstream ASI path.
- LOCKED  out  1  high when the selected channel has delivered a sync since the last switch.
- TIMEOUT_ERR  out  1  one-cycle pulse on any timeout.

## Operation
- SW synchronizer: two flops, reset to 0, giving sw_s.
- Debounce: registers cand (2b), cnt (CNT_W), req (2b), all reset to 0.
  - If sw_s != cand: cand<=sw_s, cnt<=0.
  - Else if cnt == DEBOUNCE_CYCLES-1: req<=cand; cnt holds.
  - Else cnt<=cnt+1.
- FSM states are IDLE, WAIT_GAP, RST_PULSE and WAIT_SYNC. Registers: target (2b) and a timer (CNT_W). The timer clears on every state entry.
  - IDLE: LOCKED=1. If req != SELECT: target<=req, LOCKED<=0, go to WAIT_GAP.
  - WAIT_GAP: leave when D_VALID_BUS[SELECT]==0 or timer==TIMEOUT_CYCLES-1. A timeout exit also pulses TIMEOUT_ERR. On exit: SELECT<=target, RESET_ON_CHANGE_OUT<=1, go to RST_PULSE.
  - RST_PULSE: when timer==RESET_CYCLES-1, RESET_ON_CHANGE_OUT<=0 and go to WAIT_SYNC.
  - WAIT_SYNC has three checks, in priority order:
    - (a) If req != SELECT: target<=req, SELECT<=req, RESET_ON_CHANGE_OUT<=1, go to RST_PULSE. No gap wait, because the output is already unlocked.
    - (b) Else if P_SYNC_BUS[SELECT] & D_VALID_BUS[SELECT]: LOCKED<=1, go to IDLE.
    - (c) Else if timer==TIMEOUT_CYCLES-1: pulse TIMEOUT_ERR, clear timer, stay in WAIT_SYNC.
- req changes during WAIT_GAP or RST_PULSE are ignored until IDLE or WAIT_SYNC re-evaluates them. target is never altered mid-transition.
- Reset values: SELECT=0, RESET_ON_CHANGE_OUT=0, LOCKED=0, TIMEOUT_ERR=0, state=WAIT_SYNC. Channel 0 must therefore lock after reset before IDLE is reached.
- Counters never wrap: the debounce cnt saturates, and the timer is cleared before it reaches terminal count.

## Timing
- SW step, held stable, to req update: req changes on the (DEBOUNCE_CYCLES+3)th rising edge after the SW change. This is 2 sync edges, 1 edge for the cand load, then DEBOUNCE_CYCLES edges of counting.
- req change to WAIT_GAP entry: 1 edge when in IDLE.
- Gap already present: SELECT changes 1 edge after WAIT_GAP entry.
- SELECT and RESET_ON_CHANGE_OUT rise on the same edge. RESET_ON_CHANGE_OUT stays high for exactly RESET_CYCLES cycles.
- LOCKED rises 1 edge after the first cycle in which both P_SYNC and D_VALID of the selected channel are high. That cycle may be the first WAIT_SYNC cycle.
- TIMEOUT_ERR is high for exactly 1 cycle per timeout.
- Asserting RST at any point forces all reset values immediately, including mid-pulse.

## Test plan
- Reset, then P_SYNC_BUS[0]&D_VALID_BUS[0] high at cycle 5 -> SELECT=0, LOCKED=0 until the edge after cycle 5, then LOCKED=1, with no RESET_ON_CHANGE_OUT.
- DEBOUNCE_CYCLES=4, RESET_CYCLES=3, SW 0->2 held, D_VALID_BUS[0] low -> req=2 at edge 7; SELECT=2 and RESET_ON_CHANGE_OUT high for 3 cycles; LOCKED=0 until the ch2 sync, then 1.
- SW glitch to 1 lasting 3 cycles with DEBOUNCE_CYCLES=4 -> req, SELECT and RESET_ON_CHANGE_OUT unchanged, LOCKED stays 1.
- SW 0->3 while D_VALID_BUS[0] is held high, TIMEOUT_CYCLES=10 -> one TIMEOUT_ERR pulse after 10 WAIT_GAP cycles, then SELECT=3 with the reset pulse.
- During WAIT_SYNC on ch1 with no sync, SW debounced to 2 -> immediate SELECT=2 and a new full-length RESET_ON_CHANGE_OUT pulse. With no ch2 sync and TIMEOUT_CYCLES=10, TIMEOUT_ERR pulses every 10 cycles.
- RST asserted in the middle of RST_PULSE -> RESET_ON_CHANGE_OUT=0, SELECT=0, LOCKED=0 immediately, and the FSM restarts in WAIT_SYNC.
